mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 15 +
 rtl/resp_ram.sv | 22 ++
 rtl/mem_responder.sv | 81 ++++++++
 tb/tb_mem_responder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants, FSM encoding and request type for the fixed-latency memory responder.
package mem_responder_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_LATENCY    = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
    } req_t;

    // A request is rejected if misaligned, beyond the array, or both read and write.
    function automatic logic req_err(input logic [31:0] addr, input logic rd,
                                     input logic wr, input int aw);
        logic hi;
        hi = |(addr >> (aw + 2));
        return (addr[1:0] != 2'b00) || hi || (rd && wr);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side request/response bus of the memory responder.
interface mem_responder_if;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Mem_data;
    logic        Ready;
    logic        Err;

    modport master (output Address, Write_data, MemRead, MemWrite,
                    input  Mem_data, Ready, Err);
    modport slave  (input  Address, Write_data, MemRead, MemWrite,
                    output Mem_data, Ready, Err);
endinterface

// File: rtl/resp_ram.sv
// Single-port word array: synchronous write, asynchronous read, contents survive reset.
module resp_ram
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: latches one request, waits LATENCY cycles, answers
// with a one-cycle Ready strobe (qualified by Err) and commits writes on leaving RESP.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic [31:0] rdata_q, rdata_d;

    logic        resp, err, ram_we;
    logic [31:0] ram_rdata;

    assign resp   = (state_q == ST_RESP);
    assign err    = req_err(req_q.addr, req_q.rd, req_q.wr, ADDR_WIDTH);
    assign ram_we = resp && req_q.wr && !err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.MemRead || bus.MemWrite) begin
                    req_d   = '{addr: bus.Address, wdata: bus.Write_data,
                                rd: bus.MemRead, wr: bus.MemWrite};
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (req_q.rd && !err) rdata_d = ram_rdata;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    resp_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (req_q.addr[ADDR_WIDTH+1:2]),
        .wdata_i (req_q.wdata),
        .rdata_o (ram_rdata)
    );

    // Read data shows through during RESP and is held in rdata_q afterwards.
    assign bus.Ready    = resp;
    assign bus.Err      = resp && err;
    assign bus.Mem_data = (resp && req_q.rd && !err) ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=0 and a LATENCY=2 instance checked against a word-array model.
module tb_mem_responder;

    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst2_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if b0 ();
    mem_responder_if b2 ();

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) dut0 (.clk(clk), .reset(rst0_n), .bus(b0));
    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) dut2 (.clk(clk), .reset(rst2_n), .bus(b2));

    int total = 0;
    int bad   = 0;

    logic [31:0] m0 [256];
    logic [31:0] m2 [256];
    logic [31:0] md0 = 32'h0;
    logic [31:0] md2 = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input bit s2);
        return s2 ? b2.Ready : b0.Ready;
    endfunction
    function automatic logic errs(input bit s2);
        return s2 ? b2.Err : b0.Err;
    endfunction
    function automatic logic [31:0] mds(input bit s2);
        return s2 ? b2.Mem_data : b0.Mem_data;
    endfunction

    task automatic drive(input bit s2, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (s2) begin
            b2.MemRead = rd; b2.MemWrite = wr; b2.Address = a; b2.Write_data = d;
        end else begin
            b0.MemRead = rd; b0.MemWrite = wr; b0.Address = a; b0.Write_data = d;
        end
    endtask

    task automatic scramble(input bit s2);
        drive(s2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    // One complete transaction; the model is updated from the request rules alone.
    task automatic op(input bit s2, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input bit scr, input bit nowait, output int acc);
        int   lat, n;
        bit   seen, err_early, eerr;
        logic [7:0] w;
        lat = s2 ? 2 : 0;
        w   = a[9:2];
        if (!nowait) @(negedge clk);
        drive(s2, rd, wr, a, d);
        @(posedge clk);
        #1 acc = cyc;
        if (scr) scramble(s2);
        else     drive(s2, 1'b0, 1'b0, $urandom, $urandom);
        seen = 0; err_early = 0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rdy(s2)) begin seen = 1; break; end
            if (errs(s2)) err_early = 1;
            if (scr) scramble(s2);
        end
        drive(s2, 1'b0, 1'b0, 32'h0, 32'h0);
        eerr = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 0) || (rd && wr);
        if (!eerr && rd) begin
            if (s2) md2 = m2[w]; else md0 = m0[w];
        end
        chk("ready_seen", 32'(seen), 32'd1);
        chk("ready_latency", n, lat + 1);
        chk("err_without_ready", 32'(err_early), 32'd0);
        chk("err", 32'(errs(s2)), 32'(eerr));
        chk("mem_data_resp", mds(s2), s2 ? md2 : md0);
        @(posedge clk);
        #1;
        chk("ready_one_cycle", 32'(rdy(s2)), 32'd0);
        chk("mem_data_hold", mds(s2), s2 ? md2 : md0);
        if (!eerr && wr) begin
            if (s2) m2[w] = d; else m0[w] = d;
        end
    endtask

    initial begin
        int          acc, a1, a2;
        bit          any_rdy;
        logic [31:0] v, a;
        int          r;

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst0_n = 1'b0; rst2_n = 1'b0;
        #12;
        chk("rst_ready0", 32'(b0.Ready), 32'd0);
        chk("rst_err0",   32'(b0.Err),   32'd0);
        chk("rst_data0",  b0.Mem_data,   32'h0);
        chk("rst_ready2", 32'(b2.Ready), 32'd0);
        chk("rst_err2",   32'(b2.Err),   32'd0);
        chk("rst_data2",  b2.Mem_data,   32'h0);

        // Reset released on a falling edge; the very next rising edge must accept.
        @(negedge clk);
        rst0_n = 1'b1; rst2_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            op(1'b1, 1'b0, 1'b1, 32'(i) << 2, v, 1'b0, i == 0, acc);
        end
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            op(1'b0, 1'b0, 1'b1, 32'(i) << 2, v, 1'b0, 1'b0, acc);
        end

        // LATENCY=2 write then read
        op(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, acc);
        op(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, acc);
        chk("lat2_readback", b2.Mem_data, 32'hDEADBEEF);

        // LATENCY=0 back-to-back at minimum spacing
        v = $urandom;
        op(1'b0, 1'b0, 1'b1, 32'h0, v, 1'b0, 1'b0, a1);
        op(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, a2);
        chk("lat0_spacing", a2 - a1, 2);
        chk("lat0_readback", b0.Mem_data, v);

        // Rejected requests: misaligned, out of range, read+write together
        op(1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, acc);
        op(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, acc);
        chk("err_data_kept", b2.Mem_data, 32'hDEADBEEF);
        op(1'b1, 1'b0, 1'b1, 32'h401, 32'h55AA55AA, 1'b0, 1'b0, acc);
        op(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, acc);
        op(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        v = m2[8];
        op(1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, acc);
        op(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, acc);
        chk("rdwr_prior_kept", b2.Mem_data, v);

        // Reset during WAIT aborts the write
        v = m2[2];
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst2_n = 1'b0;
        #1;
        chk("abort_ready", 32'(b2.Ready), 32'd0);
        chk("abort_err",   32'(b2.Err),   32'd0);
        chk("abort_data",  b2.Mem_data,   32'h0);
        md2 = 32'h0;
        @(negedge clk);
        rst2_n = 1'b1;
        any_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b2.Ready) any_rdy = 1;
        end
        chk("abort_no_ready", 32'(any_rdy), 32'd0);
        op(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, acc);
        chk("abort_prior_kept", b2.Mem_data, v);

        // Inputs wiggled after acceptance must not affect the stored data
        v = $urandom;
        op(1'b1, 1'b0, 1'b1, 32'h4, v, 1'b1, 1'b0, acc);
        op(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, acc);
        chk("latched_wdata", b2.Mem_data, v);

        // Random traffic on both instances
        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = ($urandom & 32'h3FF) | 32'h1;
            else if (r == 1) a = 32'h400 << $urandom_range(0, 21);
            else             a = 32'($urandom_range(0, 255)) << 2;
            r = $urandom_range(0, 5);
            op(k[0], r == 0 || r > 2, r <= 2, a, $urandom, k[2], 1'b0, acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
